scramble_ctrl: RTL

SCRAMBLE_CTRL -- requirements
Module: scramble_ctrl

---
 rtl/scramble_ctrl_pkg.sv | 17 +
 rtl/scr_credit_cnt.sv | 30 +++
 rtl/scramble_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/scramble_ctrl_pkg.sv
// Shared definitions for the scramble controller: FSM encoding, default
// codeword size and the byte granularity of the scramble sequence.
package scramble_ctrl_pkg;

    localparam int MAX_BITS      = 4096;
    localparam int BITS_PER_BYTE = 8;
    localparam int BIB_W         = $clog2(BITS_PER_BYTE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/scr_credit_cnt.sv
// Scramble-byte credit counter: counts bytes available from the sequence
// generator (0..2), consumed one byte at a time by the codeword reader.
module scr_credit_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] credit,
    output logic       overflow
);

    // A byte arriving while consuming one at full credit is not lost.
    assign overflow = inc && !dec && (credit == 2'd2);

    // NOTE: clocked state is only ever assigned with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= 2'd0;
        end else if (clr) begin
            credit <= 2'd0;
        end else if (inc && !dec && credit != 2'd2) begin
            credit <= credit + 2'd1;
        end else if (dec && !inc && credit != 2'd0) begin
            credit <= credit - 2'd1;
        end
    end

endmodule

// File: rtl/scramble_ctrl.sv
// Codeword-to-scrambler sequencer: reads codeword bits from the buffer at the
// pace allowed by scramble-byte credit and tracks scrambled output completion.
module scramble_ctrl
    import scramble_ctrl_pkg::*;
#(
    parameter int   MAX_BITS = scramble_ctrl_pkg::MAX_BITS,
    localparam int  CNT_W    = $clog2(MAX_BITS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_bits,
    output logic             o_cw_rd,
    output logic [CNT_W-2:0] o_cw_raddr,
    input  logic             i_cw_rdata,
    output logic             o_scr_start,
    output logic             o_uciCW,
    output logic             o_uciCW_valid,
    input  logic             i_scramble_valid,
    input  logic             i_scrambled_bit_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    state_t           state;
    logic [CNT_W-1:0] num_bits;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W-1:0] out_cnt_nxt;
    logic [BIB_W-1:0] bit_in_byte;
    logic [1:0]       credit;
    logic             credit_ovf;
    logic             rd_go;
    logic             byte_done;
    logic             scr_start_q;
    logic             uci_valid_q;
    logic             err_q;

    assign rd_go       = (state == ST_STREAM) && (credit != 2'd0) && (rd_cnt < num_bits);
    assign byte_done   = rd_go && (bit_in_byte == BIB_W'(BITS_PER_BYTE - 1));
    assign out_cnt_nxt = out_cnt + CNT_W'(i_scrambled_bit_valid);

    scr_credit_cnt u_credit (
        .clk      (clk),
        .rst      (rst),
        .clr      (i_start),
        .inc      (i_scramble_valid),
        .dec      (byte_done),
        .credit   (credit),
        .overflow (credit_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            num_bits    <= '0;
            rd_cnt      <= '0;
            bit_in_byte <= '0;
            out_cnt     <= '0;
            scr_start_q <= 1'b0;
            uci_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            scr_start_q <= 1'b0;
            uci_valid_q <= rd_go && !i_start;
            if (credit_ovf) err_q <= 1'b1;
            if (rd_go) begin
                rd_cnt      <= rd_cnt + CNT_W'(1);
                bit_in_byte <= bit_in_byte + BIB_W'(1);
            end
            if (i_scrambled_bit_valid) out_cnt <= out_cnt_nxt;

            // NOTE: this branch comes last so a (re)start overrides the
            // counter updates above within the same clock.
            if (i_start) begin
                num_bits    <= i_num_bits;
                rd_cnt      <= '0;
                bit_in_byte <= '0;
                out_cnt     <= '0;
                scr_start_q <= 1'b1;
                err_q       <= 1'b0;
                state       <= (i_num_bits == '0) ? ST_DONE : ST_PRIME;
            end else begin
                case (state)
                    ST_IDLE:   state <= ST_IDLE;
                    ST_PRIME:  if (credit != 2'd0) state <= ST_STREAM;
                    ST_STREAM: if (rd_go && (rd_cnt + CNT_W'(1) == num_bits)) state <= ST_DRAIN;
                    ST_DRAIN:  if (out_cnt_nxt == num_bits) state <= ST_DONE;
                    ST_DONE:   state <= ST_IDLE;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_cw_rd       = rd_go;
    assign o_cw_raddr    = rd_cnt[CNT_W-2:0];
    assign o_uciCW       = i_cw_rdata;
    assign o_uciCW_valid = uci_valid_q;
    assign o_scr_start   = scr_start_q;
    assign o_busy        = (state != ST_IDLE);
    assign o_done        = (state == ST_DONE);
    assign o_err         = err_q;

endmodule
